// File: rtl/mem_writeback.sv
// mem_writeback: memory (M) and writeback (W) pipeline stages.
//   The M register captures execute-stage results and drives the data-memory
//   port. A two-state FSM (IDLE/ACCESS) holds the pipeline while a memory
//   access waits for MemReady. A wait counter bounds each access to TIMEOUT
//   wait cycles. An access that runs out of time completes as a bubble and
//   sets the sticky MemErr flag. The W register feeds the result mux back to
//   decode.
// Ports:
//   clk, reset                     clock, async active-high reset
//   RegWriteE..WA3E                execute-stage inputs
//   MemAddr/MemWData/MemWE/MemRE   data memory request
//   MemRData/MemReady              data memory response
//   StallM                         hold execute and earlier stages
//   ALUOutM/WA3M/RegWriteM         M-stage forwarding/hazard info
//   ResultW/WA3W/RegWriteW         writeback to the register file
//   PCWriteW                       writeback targets R15
//   MemErr                         sticky memory timeout flag
module mem_writeback #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        MemToRegE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WA3E,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWE,
    output logic        MemRE,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic        StallM,
    output logic [31:0] ALUOutM,
    output logic [3:0]  WA3M,
    output logic        RegWriteM,
    output logic [31:0] ResultW,
    output logic [3:0]  WA3W,
    output logic        RegWriteW,
    output logic        PCWriteW,
    output logic        MemErr
);

    localparam logic [3:0] W_TMO = 4'(TIMEOUT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wait;
    logic        r_mem_err;

    logic        r_RegWriteM;
    logic        r_MemWriteM;
    logic        r_MemToRegM;
    logic [31:0] r_ALUOutM;
    logic [31:0] r_WriteDataM;
    logic [3:0]  r_WA3M;

    logic [31:0] r_ALUOutW;
    logic [31:0] r_ReadDataW;
    logic [3:0]  r_WA3W;
    logic        r_RegWriteW;
    logic        r_MemToRegW;

    logic w_access;
    logic w_stall;
    logic w_timeout;
    logic w_mem_op_e;
    logic w_rdata_valid;

    assign w_access      = (r_state == ACCESS);
    assign w_stall       = w_access && !MemReady && (r_wait < W_TMO);
    // Out of wait budget: the access ends this cycle without data.
    assign w_timeout     = w_access && !MemReady && (r_wait >= W_TMO);
    assign w_mem_op_e    = MemWriteE || MemToRegE;
    assign w_rdata_valid = w_access && MemReady;

    // FSM, wait counter and sticky error flag. A new memory op entering M on
    // the completion edge keeps the FSM in ACCESS with a fresh counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wait    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_timeout)
                r_mem_err <= 1'b1;
            if (w_stall) begin
                r_wait <= r_wait + 4'd1;
            end else if (w_mem_op_e) begin
                r_state <= ACCESS;
                r_wait  <= '0;
            end else begin
                r_state <= IDLE;
                r_wait  <= '0;
            end
        end
    end

    // M register: loads whenever the stage is not stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_RegWriteM  <= 1'b0;
            r_MemWriteM  <= 1'b0;
            r_MemToRegM  <= 1'b0;
            r_ALUOutM    <= '0;
            r_WriteDataM <= '0;
            r_WA3M       <= '0;
        end else if (!w_stall) begin
            r_RegWriteM  <= RegWriteE;
            r_MemWriteM  <= MemWriteE;
            r_MemToRegM  <= MemToRegE;
            r_ALUOutM    <= ALUResultE;
            r_WriteDataM <= WriteDataE;
            r_WA3M       <= WA3E;
        end
    end

    // W register: bubble while stalled; a timed-out access retires with its
    // register write suppressed. Read data is captured only when the memory
    // actually returned it so stale bus values never reach ResultW.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ALUOutW   <= '0;
            r_ReadDataW <= '0;
            r_WA3W      <= '0;
            r_RegWriteW <= 1'b0;
            r_MemToRegW <= 1'b0;
        end else if (w_stall) begin
            r_RegWriteW <= 1'b0;
        end else begin
            r_ALUOutW   <= r_ALUOutM;
            r_ReadDataW <= w_rdata_valid ? MemRData : '0;
            r_WA3W      <= r_WA3M;
            r_RegWriteW <= r_RegWriteM && !w_timeout;
            r_MemToRegW <= r_MemToRegM;
        end
    end

    assign MemAddr   = r_ALUOutM;
    assign MemWData  = r_WriteDataM;
    assign MemWE     = w_access && r_MemWriteM;
    assign MemRE     = w_access && r_MemToRegM;

    assign StallM    = w_stall;
    assign ALUOutM   = r_ALUOutM;
    assign WA3M      = r_WA3M;
    assign RegWriteM = r_RegWriteM;

    assign ResultW   = r_MemToRegW ? r_ReadDataW : r_ALUOutW;
    assign WA3W      = r_WA3W;
    assign RegWriteW = r_RegWriteW;
    assign PCWriteW  = r_RegWriteW && (r_WA3W == 4'hF);
    assign MemErr    = r_mem_err;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed self-checking bench for mem_writeback.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWriteE = 1'b0, MemWriteE = 1'b0, MemToRegE = 1'b0;
    logic [31:0] ALUResultE = '0, WriteDataE = '0;
    logic [3:0]  WA3E = '0;
    logic [31:0] MemAddr, MemWData, MemRData = '0;
    logic        MemWE, MemRE, MemReady = 1'b0;
    logic        StallM, RegWriteM, RegWriteW, PCWriteW, MemErr;
    logic [31:0] ALUOutM, ResultW;
    logic [3:0]  WA3M, WA3W;

    int total = 0;
    int bad = 0;

    mem_writeback #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRE(MemRE),
        .MemRData(MemRData), .MemReady(MemReady),
        .StallM(StallM), .ALUOutM(ALUOutM), .WA3M(WA3M), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .WA3W(WA3W), .RegWriteW(RegWriteW),
        .PCWriteW(PCWriteW), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic rw, input logic mw, input logic m2r,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [3:0] wa);
        RegWriteE = rw; MemWriteE = mw; MemToRegE = m2r;
        ALUResultE = alu; WriteDataE = wd; WA3E = wa;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(); tick();
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", StallM); end
        total++; if (MemRE !== 1'b0 || MemWE !== 1'b0) begin bad++; $display("FAIL rst_mem re=%0h we=%0h exp=0", MemRE, MemWE); end
        total++; if (RegWriteW !== 1'b0 || PCWriteW !== 1'b0) begin bad++; $display("FAIL rst_wb rw=%0h pc=%0h exp=0", RegWriteW, PCWriteW); end
        total++; if (ResultW !== 32'h0) begin bad++; $display("FAIL rst_result got=%0h exp=0", ResultW); end
        total++; if (MemErr !== 1'b0 || RegWriteM !== 1'b0) begin bad++; $display("FAIL rst_err err=%0h rwm=%0h exp=0", MemErr, RegWriteM); end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        drive_e(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'd3);
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (RegWriteM !== 1'b1 || ALUOutM !== 32'h1234 || WA3M !== 4'd3) begin bad++; $display("FAIL alu_m rw=%0h alu=%0h wa=%0h exp 1/1234/3", RegWriteM, ALUOutM, WA3M); end
        total++; if (StallM !== 1'b0 || MemRE !== 1'b0) begin bad++; $display("FAIL alu_nostall stall=%0h re=%0h exp=0", StallM, MemRE); end
        tick();
        total++; if (RegWriteW !== 1'b1 || WA3W !== 4'd3 || ResultW !== 32'h1234) begin bad++; $display("FAIL alu_w rw=%0h wa=%0h res=%0h exp 1/3/1234", RegWriteW, WA3W, ResultW); end
        total++; if (PCWriteW !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL alu_pc pc=%0h stall=%0h exp=0", PCWriteW, StallM); end
    endtask

    task automatic test_load();
        int re_cnt = 0, st_cnt = 0, addr_bad = 0, bub_bad = 0;
        drive_e(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'd5);
        MemReady = 1'b0;
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            MemReady = (i == 3);
            MemRData = (i == 3) ? 32'hDEADBEEF : 32'h0BAD0BAD;
            #1;
            if (MemRE === 1'b1) re_cnt++;
            if (StallM === 1'b1) st_cnt++;
            if (MemAddr !== 32'h40) addr_bad++;
            if (i > 0 && RegWriteW !== 1'b0) bub_bad++;
            tick();
        end
        MemReady = 1'b0;
        MemRData = 32'h0BAD0BAD;
        #1;
        total++; if (re_cnt != 4 || addr_bad != 0) begin bad++; $display("FAIL load_re cycles=%0d addrbad=%0d exp 4/0", re_cnt, addr_bad); end
        total++; if (st_cnt != 3) begin bad++; $display("FAIL load_stall cycles=%0d exp=3", st_cnt); end
        total++; if (bub_bad != 0) begin bad++; $display("FAIL load_bubble count=%0d exp=0", bub_bad); end
        total++; if (ResultW !== 32'hDEADBEEF || RegWriteW !== 1'b1 || WA3W !== 4'd5) begin bad++; $display("FAIL load_w res=%0h rw=%0h wa=%0h exp deadbeef/1/5", ResultW, RegWriteW, WA3W); end
        total++; if (MemRE !== 1'b0 || StallM !== 1'b0) begin bad++; $display("FAIL load_done re=%0h stall=%0h exp=0", MemRE, StallM); end
    endtask

    task automatic test_store();
        drive_e(1'b0, 1'b1, 1'b0, 32'h80, 32'hA5A5A5A5, 4'd6);
        MemReady = 1'b1;
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (MemWE !== 1'b1 || MemWData !== 32'hA5A5A5A5 || MemAddr !== 32'h80) begin bad++; $display("FAIL st_req we=%0h wd=%0h a=%0h exp 1/a5a5a5a5/80", MemWE, MemWData, MemAddr); end
        total++; if (StallM !== 1'b0 || MemRE !== 1'b0) begin bad++; $display("FAIL st_ctl stall=%0h re=%0h exp=0", StallM, MemRE); end
        tick();
        MemReady = 1'b0;
        #1;
        total++; if (MemWE !== 1'b0) begin bad++; $display("FAIL st_once we=%0h exp=0", MemWE); end
        total++; if (RegWriteW !== 1'b0 || PCWriteW !== 1'b0) begin bad++; $display("FAIL st_bubble rw=%0h pc=%0h exp=0", RegWriteW, PCWriteW); end
    endtask

    task automatic test_back_to_back();
        MemReady = 1'b1;
        drive_e(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'd1);
        tick();
        drive_e(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 4'd2);
        MemRData = 32'h111;
        #1;
        total++; if (MemRE !== 1'b1 || MemAddr !== 32'h10 || StallM !== 1'b0) begin bad++; $display("FAIL b2b_ld1 re=%0h a=%0h st=%0h exp 1/10/0", MemRE, MemAddr, StallM); end
        tick();
        drive_e(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 4'd3);
        MemRData = 32'h222;
        #1;
        total++; if (MemRE !== 1'b1 || MemAddr !== 32'h20) begin bad++; $display("FAIL b2b_ld2 re=%0h a=%0h exp 1/20", MemRE, MemAddr); end
        total++; if (ResultW !== 32'h111 || WA3W !== 4'd1 || RegWriteW !== 1'b1) begin bad++; $display("FAIL b2b_w1 res=%0h wa=%0h rw=%0h exp 111/1/1", ResultW, WA3W, RegWriteW); end
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        MemRData = 32'h333;
        #1;
        total++; if (ResultW !== 32'h222 || WA3W !== 4'd2 || MemRE !== 1'b0) begin bad++; $display("FAIL b2b_w2 res=%0h wa=%0h re=%0h exp 222/2/0", ResultW, WA3W, MemRE); end
        tick();
        MemReady = 1'b0;
        #1;
        total++; if (ResultW !== 32'h30 || WA3W !== 4'd3) begin bad++; $display("FAIL b2b_w3 res=%0h wa=%0h exp 30/3", ResultW, WA3W); end
    endtask

    task automatic test_timeout();
        int st_cnt = 0;
        bit ended = 0;
        MemReady = 1'b0;
        drive_e(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 4'd7);
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 40 && !ended; i++) begin
            #1;
            if (StallM === 1'b1) begin
                st_cnt++;
                tick();
            end else begin
                ended = 1;
            end
        end
        total++; if (!ended || st_cnt != 15) begin bad++; $display("FAIL tmo_stall ended=%0d cycles=%0d exp 1/15", ended, st_cnt); end
        total++; if (MemRE !== 1'b1 || MemErr !== 1'b0) begin bad++; $display("FAIL tmo_last re=%0h err=%0h exp 1/0", MemRE, MemErr); end
        tick();
        #1;
        total++; if (MemErr !== 1'b1 || RegWriteW !== 1'b0) begin bad++; $display("FAIL tmo_err err=%0h rw=%0h exp 1/0", MemErr, RegWriteW); end
        total++; if (StallM !== 1'b0 || MemRE !== 1'b0) begin bad++; $display("FAIL tmo_resume st=%0h re=%0h exp=0", StallM, MemRE); end
        drive_e(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd2);
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        total++; if (RegWriteW !== 1'b1 || ResultW !== 32'h55 || MemErr !== 1'b1) begin bad++; $display("FAIL tmo_after rw=%0h res=%0h err=%0h exp 1/55/1", RegWriteW, ResultW, MemErr); end
    endtask

    task automatic test_pc_reset();
        drive_e(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        tick();
        drive_e(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 4'd4);
        MemReady = 1'b0;
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (PCWriteW !== 1'b1 || ResultW !== 32'h100) begin bad++; $display("FAIL pc_w pc=%0h res=%0h exp 1/100", PCWriteW, ResultW); end
        tick();
        total++; if (MemRE !== 1'b1 || StallM !== 1'b1) begin bad++; $display("FAIL pc_ld re=%0h st=%0h exp 1/1", MemRE, StallM); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (StallM !== 1'b0 || MemRE !== 1'b0 || MemWE !== 1'b0) begin bad++; $display("FAIL arst_mem st=%0h re=%0h we=%0h exp=0", StallM, MemRE, MemWE); end
        total++; if (RegWriteM !== 1'b0 || RegWriteW !== 1'b0 || PCWriteW !== 1'b0) begin bad++; $display("FAIL arst_rw m=%0h w=%0h pc=%0h exp=0", RegWriteM, RegWriteW, PCWriteW); end
        total++; if (ResultW !== 32'h0 || MemErr !== 1'b0 || ALUOutM !== 32'h0) begin bad++; $display("FAIL arst_data res=%0h err=%0h alu=%0h exp=0", ResultW, MemErr, ALUOutM); end
        MemReady = 1'b1;
        tick();
        reset = 1'b0;
        drive_e(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd9);
        MemReady = 1'b0;
        tick();
        drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        total++; if (RegWriteM !== 1'b1 || ALUOutM !== 32'h77 || RegWriteW !== 1'b0 || MemErr !== 1'b0) begin bad++; $display("FAIL post_rst rwm=%0h alu=%0h rww=%0h err=%0h exp 1/77/0/0", RegWriteM, ALUOutM, RegWriteW, MemErr); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_pc_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk  in  1  rising-edge clock.
REQ-003 Port reset  in  1  asynchronous active-high reset.
REQ-004 Ports from execute SHALL be: RegWriteE in 1 (condition-qualified); MemWriteE in 1; MemToRegE in 1; ALUResultE in 32; WriteDataE in 32; WA3E in 4.
REQ-005 Data memory ports SHALL be: MemAddr out 32; MemWData out 32; MemWE out 1; MemRE out 1; MemRData in 32; MemReady in 1 (access done this cycle).
REQ-006 Hazard/forwarding ports SHALL be: StallM out 1 (hold execute and earlier stages); ALUOutM out 32; WA3M out 4; RegWriteM out 1.
REQ-007 Writeback ports to decode SHALL be: ResultW out 32; WA3W out 4; RegWriteW out 1; PCWriteW out 1 (R15 written); MemErr out 1 (sticky timeout flag).
REQ-008 Parameter TIMEOUT, default 15, SHALL set the maximum number of wait cycles per memory access.

Function
REQ-009 The M register {RegWriteM, MemWriteM, MemToRegM, ALUOutM, WriteDataM, WA3M} SHALL load the E inputs on each rising edge where StallM=0 and hold otherwise.
REQ-010 A memory op in M is MemWriteM=1 or MemToRegM=1; MemAddr=ALUOutM; MemWData=WriteDataM; MemWE=MemWriteM and MemRE=MemToRegM, both only while the FSM is in ACCESS.
REQ-011 The FSM SHALL have states IDLE and ACCESS.
REQ-012 IDLE -> ACCESS SHALL occur on the edge that loads a memory op into M. ACCESS -> IDLE SHALL occur on MemReady=1 or on timeout, unless a new memory op loads on the same edge, in which case the FSM stays in ACCESS.
REQ-013 StallM SHALL equal 1 when the FSM is in ACCESS, MemReady=0 and the wait counter is below TIMEOUT.
REQ-014 MemReady=1 in the first ACCESS cycle SHALL give zero added latency; each MemReady=0 cycle SHALL add exactly one stall cycle.
REQ-015 The wait counter (4 bits) SHALL clear on entering ACCESS and increment on each ACCESS cycle with MemReady=0. When it reaches TIMEOUT, the access SHALL complete in that cycle as a bubble and set MemErr=1 until reset.
REQ-016 The W register SHALL load {ALUOutM, MemRData, WA3M, RegWriteM, MemToRegM} on the edge where M completes: non-memory op, MemReady=1 in ACCESS, or timeout with RegWriteW forced to 0.
REQ-017 While StallM=1, W SHALL load a bubble (RegWriteW=0, PCWriteW=0); WA3W and data SHALL be don't-care.
REQ-018 ResultW SHALL be ReadDataW when MemToRegW=1, else ALUOutW; the mux is combinational from W-register outputs.
REQ-019 PCWriteW SHALL equal RegWriteW AND (WA3W==4'hF).
REQ-020 A store SHALL never assert RegWriteW unless RegWriteE was 1 for that instruction; a store with RegWriteE=0 SHALL produce a W bubble.
REQ-021 Latency SHALL be: E inputs visible at M outputs 1 cycle after capture, and at W outputs 2 cycles after capture when not stalled.
REQ-022 MemRData SHALL be sampled only in the cycle MemReady=1 in ACCESS; its value at other times SHALL NOT affect any output.

Reset
REQ-023 Asserting reset SHALL immediately clear all M and W registers to 0, FSM to IDLE, counter and MemErr to 0. Consequently StallM, MemWE, MemRE, RegWriteM, RegWriteW and PCWriteW SHALL be 0 and ResultW=0.
REQ-024 Reset asserted during ACCESS SHALL abort the access with no W write and no MemErr.
REQ-025 After reset deassertion, the first capture SHALL occur on the next rising edge.

Verification
REQ-026 ALU op, RegWriteE=1, ALUResultE=32'h0000_1234, WA3E=3 -> 2 cycles later RegWriteW=1, WA3W=3, ResultW=32'h1234, StallM=0 throughout.
REQ-027 Load, ALUResultE=32'h40, MemReady low 3 cycles then high with MemRData=32'hDEADBEEF -> MemRE=1 and MemAddr=32'h40 for 4 cycles, StallM=1 for 3 cycles, then ResultW=32'hDEADBEEF with RegWriteW=1.
REQ-028 Store, WriteDataE=32'hA5A5A5A5, RegWriteE=0, MemReady=1 immediately -> MemWE=1 for exactly 1 cycle, MemWData=32'hA5A5A5A5, W bubble.
REQ-029 Load with MemReady held 0 -> StallM=1 for 15 cycles, then MemErr=1, RegWriteW=0, pipeline resumes.
REQ-030 ALU op with WA3E=15, ALUResultE=32'h100 -> PCWriteW=1 and ResultW=32'h100; reset asserted mid-ACCESS of a following load -> all outputs 0 immediately.
